// File: rtl/cnt_seq_ctrl.sv
// Run/pause/clear/load sequencer for a 4-bit enable counter.
// Prescales count ticks, tracks counter wraps and auto-stops at a limit.
module cnt_seq_ctrl #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned WRAP_LIMIT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       LOAD_REQ,
  input  logic [3:0] LOAD_DATA,
  input  logic       CNT_OV,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       CNT_LOAD,
  output logic [3:0] CNT_DATA,
  output logic [1:0] STATE,
  output logic [7:0] WRAPS,
  output logic       DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  LIM     = 8'(WRAP_LIMIT);

  state_t      state;
  logic [15:0] pre;
  logic [7:0]  wraps;
  logic        clr_q;
  logic        ld_q;
  logic [3:0]  data_q;

  logic       tick;
  logic       wrap_ev;
  logic       hit;
  logic [7:0] wraps_nx;

  assign tick     = (state == S_RUN) && (pre == PRE_MAX);
  assign wrap_ev  = tick && CNT_OV;
  assign wraps_nx = (wraps == 8'hff) ? wraps : wraps + 8'd1;
  assign hit      = (LIM != 8'd0) && (wraps_nx == LIM);

  // Later assignments override earlier ones: commands beat the wrap update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      pre    <= '0;
      wraps  <= '0;
      clr_q  <= 1'b0;
      ld_q   <= 1'b0;
      data_q <= '0;
    end else begin
      clr_q <= 1'b0;
      ld_q  <= 1'b0;
      if (tick)
        pre <= '0;
      else if (state == S_RUN)
        pre <= pre + 16'd1;
      if (wrap_ev) begin
        wraps <= wraps_nx;
        if (hit)
          state <= S_DONE;
      end
      if (CLEAR) begin
        state <= S_IDLE;
        pre   <= '0;
        wraps <= '0;
        clr_q <= 1'b1;
      end else if (STOP && state == S_RUN) begin
        state <= S_PAUSE;
      end else if (LOAD_REQ &&
                   (state == S_IDLE || state == S_PAUSE)) begin
        ld_q   <= 1'b1;
        data_q <= LOAD_DATA;
      end else if (START && state == S_IDLE) begin
        state <= S_RUN;
        pre   <= '0;
      end else if (START && state == S_PAUSE) begin
        state <= S_RUN;
      end
    end
  end

  assign CNT_EN   = tick | ld_q;
  assign CNT_LOAD = ld_q;
  assign CNT_DATA = data_q;
  assign CNT_CLR  = clr_q;
  assign STATE    = state;
  assign WRAPS    = wraps;
  assign DONE     = (state == S_DONE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl driving a 0..9 counter model.
// Second instance covers TICK_DIV=1 free-run with wrap saturation.
module tb_cnt_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start, stop, clear, load_req;
  logic [3:0] load_data;
  logic       en, clr, ld, done;
  logic [3:0] data;
  logic [1:0] st;
  logic [7:0] wraps;
  logic [3:0] cnt;
  logic       ov;

  logic       start2;
  logic       en2, clr2, ld2, done2;
  logic [3:0] data2;
  logic [1:0] st2;
  logic [7:0] wraps2;
  logic [3:0] cnt2;
  logic       ov2;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  always #5 CLK = ~CLK;

  cnt_seq_ctrl #(.TICK_DIV(4), .WRAP_LIMIT(3)) dut (
    .CLK(CLK), .RST(RST),
    .START(start), .STOP(stop), .CLEAR(clear),
    .LOAD_REQ(load_req), .LOAD_DATA(load_data),
    .CNT_OV(ov),
    .CNT_EN(en), .CNT_CLR(clr), .CNT_LOAD(ld),
    .CNT_DATA(data), .STATE(st), .WRAPS(wraps),
    .DONE(done)
  );

  cnt_seq_ctrl #(.TICK_DIV(1), .WRAP_LIMIT(0)) dut2 (
    .CLK(CLK), .RST(RST),
    .START(start2), .STOP(1'b0), .CLEAR(1'b0),
    .LOAD_REQ(1'b0), .LOAD_DATA(4'd0),
    .CNT_OV(ov2),
    .CNT_EN(en2), .CNT_CLR(clr2), .CNT_LOAD(ld2),
    .CNT_DATA(data2), .STATE(st2), .WRAPS(wraps2),
    .DONE(done2)
  );

  // Decade counter with enable, synchronous clear and load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt <= 4'd0;
    else if (clr) cnt <= 4'd0;
    else if (en) cnt <= ld ? data : (cnt == 4'd9 ? 4'd0 : cnt + 4'd1);
  end
  assign ov = (cnt == 4'd9);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt2 <= 4'd0;
    else if (clr2) cnt2 <= 4'd0;
    else if (en2) cnt2 <= ld2 ? data2 : (cnt2 == 4'd9 ? 4'd0 : cnt2 + 4'd1);
  end
  assign ov2 = (cnt2 == 4'd9);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    start = 0; stop = 0; clear = 0; load_req = 0; load_data = 0;
    start2 = 0;
    cyc(2);
    chk("rst_state", 32'(st), 0);
    chk("rst_wraps", 32'(wraps), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_load", 32'(ld), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_state2", 32'(st2), 0);
    RST = 0;
    cyc(1);

    // Full run to DONE
    start = 1; cyc(1); start = 0;
    for (int i = 1; i <= 130; i++) begin
      chk("full_en", 32'(en), 32'((i % 4 == 0) && (i <= 120)));
      chk("full_done", 32'(done), 32'(i >= 121));
      chk("full_wraps", 32'(wraps),
          32'(int'(i >= 41) + int'(i >= 81) + int'(i >= 121)));
      n_pulse += int'(en);
      cyc(1);
    end
    chk("full_pulses", 32'(n_pulse), 30);
    chk("full_cnt", 32'(cnt), 0);
    chk("full_state", 32'(st), 3);

    start = 1; cyc(1); start = 0;
    chk("done_start_state", 32'(st), 3);
    chk("done_start_en", 32'(en), 0);
    clear = 1; cyc(1); clear = 0;
    chk("clr_state", 32'(st), 0);
    chk("clr_pulse", 32'(clr), 1);
    chk("clr_wraps", 32'(wraps), 0);
    chk("clr_done", 32'(done), 0);
    cyc(1);
    chk("clr_pulse_end", 32'(clr), 0);
    chk("clr_cnt", 32'(cnt), 0);

    // Pause / resume
    start = 1; cyc(1); start = 0;
    for (int i = 1; i <= 21; i++) begin
      chk("pr_en", 32'(en), 32'(i % 4 == 0));
      cyc(1);
    end
    chk("pr_cnt5", 32'(cnt), 5);
    stop = 1; cyc(1); stop = 0;
    for (int i = 23; i <= 32; i++) begin
      chk("pause_en", 32'(en), 0);
      chk("pause_state", 32'(st), 2);
      cyc(1);
    end
    start = 1; cyc(1); start = 0;
    chk("resume_state", 32'(st), 1);
    chk("resume_en0", 32'(en), 0);
    chk("resume_cnt", 32'(cnt), 5);
    cyc(1);
    chk("resume_tick", 32'(en), 1);
    stop = 1; cyc(1); stop = 0;
    chk("stop_tick_state", 32'(st), 2);
    chk("stop_tick_cnt", 32'(cnt), 6);

    // Load in PAUSE, then wrap
    load_req = 1; load_data = 7; cyc(1); load_req = 0;
    chk("load_en", 32'(en), 1);
    chk("load_ld", 32'(ld), 1);
    chk("load_data", 32'(data), 7);
    chk("load_state", 32'(st), 2);
    cyc(1);
    chk("load_cnt", 32'(cnt), 7);
    chk("load_en_end", 32'(en), 0);
    chk("load_ld_end", 32'(ld), 0);
    start = 1; cyc(1); start = 0;
    chk("load_run", 32'(st), 1);
    for (int i = 39; i <= 50; i++) begin
      chk("lw_en", 32'(en), 32'(i == 42 || i == 46 || i == 50));
      chk("lw_wraps", 32'(wraps), 0);
      cyc(1);
    end
    chk("lw_wraps1", 32'(wraps), 1);
    chk("lw_cnt", 32'(cnt), 0);
    chk("lw_state", 32'(st), 1);

    // Illegal load in RUN, then priority
    load_req = 1; load_data = 3; cyc(1); load_req = 0;
    chk("runload_ld", 32'(ld), 0);
    chk("runload_en", 32'(en), 0);
    chk("runload_data", 32'(data), 7);
    clear = 1; stop = 1; start = 1; cyc(1);
    clear = 0; stop = 0; start = 0;
    chk("prio_state", 32'(st), 0);
    chk("prio_clr", 32'(clr), 1);
    chk("prio_wraps", 32'(wraps), 0);
    cyc(1);
    chk("prio_idle", 32'(st), 0);

    // Async reset mid-RUN during a tick
    start = 1; cyc(1); start = 0;
    cyc(3);
    chk("ar_tick", 32'(en), 1);
    #2 RST = 1;
    #1;
    chk("ar_state", 32'(st), 0);
    chk("ar_en", 32'(en), 0);
    chk("ar_data", 32'(data), 0);
    chk("ar_wraps", 32'(wraps), 0);
    chk("ar_done", 32'(done), 0);
    @(negedge CLK);
    RST = 0; start = 1; cyc(1); start = 0;
    chk("ar_run", 32'(st), 1);
    cyc(2);
    chk("ar_pre_en", 32'(en), 0);
    cyc(1);
    chk("ar_first_tick", 32'(en), 1);

    // Free-run, TICK_DIV=1, WRAP_LIMIT=0
    start2 = 1; cyc(1); start2 = 0;
    for (int j = 1; j <= 2600; j++) begin
      chk("fr_en", 32'(en2), 1);
      chk("fr_done", 32'(done2), 0);
      chk("fr_wraps", 32'(wraps2), 32'((j - 1) / 10 > 255 ? 255 : (j - 1) / 10));
      cyc(1);
    end
    chk("fr_state", 32'(st2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
